// File: rtl/pipelined_adder_sub_pkg.sv
// Shared definitions for the carry-pipelined adder/subtractor: mode encoding,
// slice-width helper and the configuration legality check used at elaboration.
package pipelined_adder_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  function automatic bit cfg_ok(input int n, input int stages);
    return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_sub_if.sv
// Operand/result handshake bundle: the master drives operands and out_ready,
// the slave (the adder) returns in_ready and the registered result.
interface pipelined_adder_sub_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_sub_adder_slice.sv
// Combinational W-bit ripple of full adders; also exposes the carry into the
// top bit so the final slice can form signed overflow.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);
  logic carry;

  always_comb begin
    carry    = c_in;
    c_msb_in = c_in;
    s        = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    c_out = carry;
  end
endmodule

// File: rtl/pipelined_adder_sub.sv
// Carry-pipelined N-bit adder/subtractor: STAGES ripple slices of N/STAGES bits,
// remaining operand bits skew forward and finished sum slices shift in from the top.
module pipelined_adder_sub
  import pipelined_adder_sub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_adder_sub_if.slave bus
);
  localparam int W    = slice_width(N, STAGES);
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(N, STAGES)) begin : g_cfg_check
    $error("pipelined_adder_sub: N=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= N", N, STAGES);
  end

  logic              en;
  logic [N-1:0]      b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] carry_q;
  logic [N-1:0]      op_a     [STAGES];
  logic [N-1:0]      op_b     [STAGES];
  logic [N-1:0]      op_a_d   [STAGES];
  logic [N-1:0]      op_b_d   [STAGES];
  logic [N-1:0]      op_a_q   [STAGES];
  logic [N-1:0]      op_b_q   [STAGES];
  logic [N-1:0]      sum_prev [STAGES];
  logic [N-1:0]      sum_d    [STAGES];
  logic [N-1:0]      sum_q    [STAGES];
  logic [W-1:0]      slice_s  [STAGES];
  logic              c_msb    [STAGES];
  logic              ovf_d;
  logic              ovf_q;

  // Subtraction is a + ~b + 1: invert b once at the input and force the carry-in.
  assign b_eff   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign cin_eff = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

  assign en           = ~valid_q[LAST] | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign op_a[gi]     = bus.a;
      assign op_b[gi]     = b_eff;
      assign carry_in[gi] = cin_eff;
      assign sum_prev[gi] = '0;
      assign valid_d[gi]  = bus.in_valid;
    end else begin : g_next
      assign op_a[gi]     = op_a_q[gi-1];
      assign op_b[gi]     = op_b_q[gi-1];
      assign carry_in[gi] = carry_q[gi-1];
      assign sum_prev[gi] = sum_q[gi-1];
      assign valid_d[gi]  = valid_q[gi-1];
    end

    adder_slice #(
      .W(W)
    ) u_slice (
      .x        (op_a[gi][W-1:0]),
      .y        (op_b[gi][W-1:0]),
      .c_in     (carry_in[gi]),
      .s        (slice_s[gi]),
      .c_out    (carry_d[gi]),
      .c_msb_in (c_msb[gi])
    );

    // Consumed low slice drops off the operands; the new sum slice enters at the top.
    assign op_a_d[gi] = op_a[gi] >> W;
    assign op_b_d[gi] = op_b[gi] >> W;
    assign sum_d[gi]  = (sum_prev[gi] >> W) | (N'(slice_s[gi]) << (N - W));
  end

  assign ovf_d = c_msb[LAST] ^ carry_d[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k] <= '0;
        op_b_q[k] <= '0;
        sum_q[k]  <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k] <= op_a_d[k];
        op_b_q[k] <= op_b_d[k];
        sum_q[k]  <= sum_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Drives three pipeline depths (1, 4, 32) with a shared stream and checks each one
// every cycle against a queue-based arithmetic model of the adder/subtractor.
module tb_pipelined_adder_sub;
  localparam int N    = 32;
  localparam int NCFG = 3;

  function automatic int st_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  typedef struct {
    logic [N+1:0] res;
    int           stamp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub_m;
  logic         out_ready;
  logic         verbose = 1'b0;

  logic         rdy_w  [NCFG];
  logic         ov_w   [NCFG];
  logic [N-1:0] sum_w  [NCFG];
  logic         cout_w [NCFG];
  logic         ovf_w  [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  exp_t q      [NCFG][$];
  int   en_cnt [NCFG];

  logic [N-1:0] da   [5];
  logic [N-1:0] db   [5];
  logic         dc   [5];
  logic         ds   [5];
  logic [N+1:0] dexp [5];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    pipelined_adder_sub_if #(.N(N)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.cin       = cin;
    assign bus.sub       = sub_m;
    assign bus.out_ready = out_ready;
    assign rdy_w[gi]     = bus.in_ready;
    assign ov_w[gi]      = bus.out_valid;
    assign sum_w[gi]     = bus.sum;
    assign cout_w[gi]    = bus.cout;
    assign ovf_w[gi]     = bus.ovf;

    pipelined_adder_sub #(
      .N      (N),
      .STAGES (st_of(gi))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Reference: {ovf, cout, sum} from plain wide arithmetic and sign rules.
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic ci, input logic sb);
    logic [N:0] r;
    logic       ov;
    if (sb) begin
      r  = {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
      ov = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
      ov = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    end
    return {ov, r};
  endfunction

  task automatic check(input string nm, input int cfg, input logic [N+1:0] got, input logic [N+1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s stages=%0d got=%h expected=%h", nm, st_of(cfg), got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 15))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare: the head of each queue must be on the output exactly when it
  // has seen STAGES advancing cycles since acceptance; stalled cycles do not count.
  initial begin
    logic armed;
    logic rst_prev;
    logic ev;
    logic en_m;
    exp_t e;
    armed    = 1'b0;
    rst_prev = 1'b0;
    for (int i = 0; i < NCFG; i++) en_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
        ev = (q[i].size() > 0) && ((en_cnt[i] - q[i][0].stamp) == st_of(i));
        if (armed) begin
          check("out_valid", i, (N+2)'(ov_w[i]), (N+2)'(ev));
          check("in_ready", i, (N+2)'(rdy_w[i]), (N+2)'(!(ev && !out_ready)));
          if (rst_prev) begin
            check("reset_result", i, {ovf_w[i], cout_w[i], sum_w[i]}, '0);
          end else if (ev) begin
            check("result", i, {ovf_w[i], cout_w[i], sum_w[i]}, q[i][0].res);
            if (verbose && i == 1 && out_ready)
              $display("stages=4 out sum=%h cout=%b ovf=%b", sum_w[i], cout_w[i], ovf_w[i]);
          end
        end
        if (rst) begin
          q[i].delete();
        end else begin
          en_m = !(ev && !out_ready);
          if (ev && out_ready) void'(q[i].pop_front());
          if (in_valid && en_m) begin
            e.res   = ref_op(a, b, cin, sub_m);
            e.stamp = en_cnt[i];
            q[i].push_back(e);
          end
          if (en_m) en_cnt[i]++;
        end
      end
      rst_prev = rst;
      if (rst) armed = 1'b1;
    end
  end

  initial begin
    da   = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    db   = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
    dc   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ds   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dexp = '{{1'b0, 1'b0, 32'h0001_0000},
             {1'b0, 1'b1, 32'h0000_0000},
             {1'b1, 1'b0, 32'h8000_0000},
             {1'b0, 1'b0, 32'hFFFF_FFFE},
             {1'b1, 1'b1, 32'h7FFF_FFFF}};

    // Reset held two cycles with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub_m = 1'b0; out_ready = 1'b1;
    step();
    a = $urandom; b = $urandom;
    step();
    rst = 1'b0; in_valid = 1'b0;

    for (int i = 0; i < 5; i++) check("model_pin", 1, ref_op(da[i], db[i], dc[i], ds[i]), dexp[i]);

    // Directed ops on an idle pipe: result exactly four cycles after presentation
    verbose = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = da[i]; b = db[i]; cin = dc[i]; sub_m = ds[i]; in_valid = 1'b1;
      $display("directed op %0d a=%h b=%h cin=%b sub=%b", i, a, b, cin, sub_m);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check("directed_valid", 1, (N+2)'(ov_w[1]), (N+2)'(1));
      check("directed_result", 1, {ovf_w[1], cout_w[1], sum_w[1]}, dexp[i]);
      repeat (2) step();
    end

    // Back-pressure: out_ready follows 1,0,0 repeating
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 8);
      a = pick(); b = pick(); cin = 1'($urandom); sub_m = 1'($urandom);
      out_ready = ((c % 3) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    // Three ops in flight, then a reset pulse discards them
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub_m = 1'($urandom);
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();
    verbose = 1'b0;

    // Random traffic with random stalls and rare resets
    for (int c = 0; c < 14000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 85);
      out_ready = ($urandom_range(0, 99) < 75);
      rst       = ($urandom_range(0, 2999) == 0);
      a = pick(); b = pick(); cin = 1'($urandom); sub_m = 1'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    for (int i = 0; i < NCFG; i++) check("drained", i, (N+2)'(q[i].size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
